// File: rtl/idac_pkg.sv
// Shared constants and vector types for the segmented IDAC decoder.
package idac_pkg;

  localparam int N_THERM = 17;
  localparam int N_BIN   = 6;
  localparam int CODE_W  = 11;
  localparam int PTR_W   = 5;
  localparam int CNT_W   = CODE_W - N_BIN;
  localparam logic [CODE_W-1:0] MAX_CODE = CODE_W'(N_THERM * 2**N_BIN + 2**N_BIN - 1);

  typedef logic [N_THERM-1:0] therm_vec_t;
  typedef logic [N_BIN-1:0]   bin_vec_t;

endpackage

// File: rtl/idac_dwa_rotator.sv
// Combinational DWA core: turns on cnt units starting at pointer p,
// wrapping modulo N_THERM, and returns the pointer for the next sample.
module idac_dwa_rotator
  import idac_pkg::*;
(
  input  logic [CNT_W-1:0]   cnt_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [N_THERM-1:0] therm_o,
  output logic [PTR_W-1:0]   next_ptr_o
);

  logic [5:0] offs;
  logic [5:0] sum;

  // Unit i is on when its distance ahead of the pointer is below cnt.
  always_comb begin
    therm_o = '0;
    offs    = '0;
    for (int i = 0; i < N_THERM; i++) begin
      offs = 6'(i) + 6'(N_THERM) - {1'b0, ptr_i};
      if (offs >= 6'(N_THERM)) begin
        offs = offs - 6'(N_THERM);
      end
      therm_o[i] = (offs < {1'b0, cnt_i});
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, cnt_i};
    if (sum >= 6'(N_THERM)) begin
      sum = sum - 6'(N_THERM);
    end
    next_ptr_o = sum[PTR_W-1:0];
  end

endmodule

// File: rtl/idac_segment_decoder.sv
// Two-stage IDAC front end: saturating input register, then thermometer/binary
// segmentation with DWA rotation. Power-down behaves like a synchronous reset.
module idac_segment_decoder
  import idac_pkg::*;
(
  input  logic                clkin_i,
  input  logic                rst_i,
  input  logic                pdb_i,
  input  logic                dem_ena_i,
  input  logic                data_valid_i,
  input  logic [CODE_W-1:0]   data_in_i,
  output logic [N_THERM-1:0]  therm_sel_o,
  output logic [N_BIN-1:0]    bin_sel_o,
  output logic                bin0_red_sel_o,
  output logic                out_valid_o,
  output logic                sat_flag_o,
  output logic [PTR_W-1:0]    dem_ptr_o
);

  logic [CODE_W-1:0] code_s1_q, code_s1_d;
  logic              sat_s1_q, sat_s1_d;
  logic              dem_s1_q, dem_s1_d;
  logic              v_s1_q, v_s1_d;

  therm_vec_t        therm_q, therm_d;
  bin_vec_t          bin_q, bin_d;
  logic              red_q, red_d;
  logic              sat_q, sat_d;
  logic              ovalid_q, ovalid_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [CNT_W-1:0]  cnt;
  logic [PTR_W-1:0]  ptr_sel;
  therm_vec_t        rot_therm;
  logic [PTR_W-1:0]  rot_next;

  // Stage 1 clamps to full scale; registers hold when no sample arrives.
  always_comb begin
    code_s1_d = code_s1_q;
    sat_s1_d  = sat_s1_q;
    dem_s1_d  = dem_s1_q;
    v_s1_d    = data_valid_i;
    if (data_valid_i) begin
      sat_s1_d  = (data_in_i > MAX_CODE);
      code_s1_d = (data_in_i > MAX_CODE) ? MAX_CODE : data_in_i;
      dem_s1_d  = dem_ena_i;
    end
  end

  assign cnt     = code_s1_q[CODE_W-1:N_BIN];
  assign ptr_sel = dem_s1_q ? ptr_q : '0;

  idac_dwa_rotator u_rotator (
    .cnt_i      (cnt),
    .ptr_i      (ptr_sel),
    .therm_o    (rot_therm),
    .next_ptr_o (rot_next)
  );

  // Stage 2 holds the last DAC level across gaps in the sample stream.
  always_comb begin
    therm_d  = therm_q;
    bin_d    = bin_q;
    red_d    = red_q;
    sat_d    = sat_q;
    ptr_d    = ptr_q;
    ovalid_d = v_s1_q;
    if (v_s1_q) begin
      therm_d = rot_therm;
      bin_d   = code_s1_q[N_BIN-1:0];
      red_d   = code_s1_q[0];
      sat_d   = sat_s1_q;
      ptr_d   = dem_s1_q ? rot_next : '0;
    end
  end

  always_ff @(posedge clkin_i) begin
    if (rst_i || !pdb_i) begin
      code_s1_q <= '0;
      sat_s1_q  <= 1'b0;
      dem_s1_q  <= 1'b0;
      v_s1_q    <= 1'b0;
      therm_q   <= '0;
      bin_q     <= '0;
      red_q     <= 1'b0;
      sat_q     <= 1'b0;
      ovalid_q  <= 1'b0;
      ptr_q     <= '0;
    end else begin
      code_s1_q <= code_s1_d;
      sat_s1_q  <= sat_s1_d;
      dem_s1_q  <= dem_s1_d;
      v_s1_q    <= v_s1_d;
      therm_q   <= therm_d;
      bin_q     <= bin_d;
      red_q     <= red_d;
      sat_q     <= sat_d;
      ovalid_q  <= ovalid_d;
      ptr_q     <= ptr_d;
    end
  end

  assign therm_sel_o    = therm_q;
  assign bin_sel_o      = bin_q;
  assign bin0_red_sel_o = red_q;
  assign sat_flag_o     = sat_q;
  assign out_valid_o    = ovalid_q;
  assign dem_ptr_o      = ptr_q;

endmodule

// File: tb/tb_idac_segment_decoder.sv
// Directed and randomized checks of idac_segment_decoder against an
// arithmetic reference model of the segmentation and DWA rules.
module tb_idac_segment_decoder;

  logic        clk = 1'b0;
  logic        rst, pdb, demEna, dataValid;
  logic [10:0] dataIn;
  logic [16:0] thermSel;
  logic [5:0]  binSel;
  logic        redSel, outValid, satFlag;
  logic [4:0]  demPtr;

  int nTests = 0;
  int nFails = 0;

  // Reference model state (plain integers)
  int  mV1, mCode1, mSat1, mDem1;
  int  mTherm, mBin, mRed, mSat, mOv, mPtr;

  always #5 clk = ~clk;

  idac_segment_decoder dut (
    .clkin_i        (clk),
    .rst_i          (rst),
    .pdb_i          (pdb),
    .dem_ena_i      (demEna),
    .data_valid_i   (dataValid),
    .data_in_i      (dataIn),
    .therm_sel_o    (thermSel),
    .bin_sel_o      (binSel),
    .bin0_red_sel_o (redSel),
    .out_valid_o    (outValid),
    .sat_flag_o     (satFlag),
    .dem_ptr_o      (demPtr)
  );

  function automatic int modelTherm(int cnt, int p);
    int v = 0;
    for (int i = 0; i < 17; i++) begin
      if ((((i - p) % 17) + 17) % 17 < cnt) v = v | (1 << i);
    end
    return v;
  endfunction

  task automatic modelClear();
    mV1 = 0; mCode1 = 0; mSat1 = 0; mDem1 = 0;
    mTherm = 0; mBin = 0; mRed = 0; mSat = 0; mOv = 0; mPtr = 0;
  endtask

  // One clock edge as seen by the model, using the inputs present at the edge.
  task automatic modelEdge();
    int cnt, p;
    if (rst || !pdb) begin
      modelClear();
      return;
    end
    mOv = mV1;
    if (mV1 != 0) begin
      cnt    = mCode1 / 64;
      p      = (mDem1 != 0) ? mPtr : 0;
      mTherm = modelTherm(cnt, p);
      mBin   = mCode1 % 64;
      mRed   = mCode1 % 2;
      mSat   = mSat1;
      mPtr   = (mDem1 != 0) ? (p + cnt) % 17 : 0;
    end
    mV1 = dataValid;
    if (dataValid) begin
      mSat1  = (int'(dataIn) > 1151) ? 1 : 0;
      mCode1 = (int'(dataIn) > 1151) ? 1151 : int'(dataIn);
      mDem1  = demEna;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    chk("therm_sel", 32'(thermSel), 32'(mTherm));
    chk("bin_sel", 32'(binSel), 32'(mBin));
    chk("bin0_red_sel", 32'(redSel), 32'(mRed));
    chk("sat_flag", 32'(satFlag), 32'(mSat));
    chk("out_valid", 32'(outValid), 32'(mOv));
    chk("dem_ptr", 32'(demPtr), 32'(mPtr));
  endtask

  task automatic applyStimulus(input logic r, input logic pd, input logic de,
                               input logic dv, input logic [10:0] d);
    rst = r; pdb = pd; demEna = de; dataValid = dv; dataIn = d;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  initial begin
    logic [10:0] rd;
    int          r;
    rst = 1'b1; pdb = 1'b1; demEna = 1'b0; dataValid = 1'b1; dataIn = 11'd500;
    modelClear();
    #1;

    // Reset held with a valid sample present
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 11'd500);
    chk("reset_therm", 32'(thermSel), 32'h0);
    chk("reset_ptr", 32'(demPtr), 32'h0);

    // First valid sample after release: out_valid two edges later
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd200);
    chk("latency_edge1", 32'(outValid), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    chk("fixed_therm", 32'(thermSel), 32'h00007);
    chk("fixed_bin", 32'(binSel), 32'd8);
    chk("fixed_ptr", 32'(demPtr), 32'd0);
    chk("latency_edge2", 32'(outValid), 32'h1);

    // DWA rotation, cnt=5 each sample
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    chk("dwa_ptr1", 32'(demPtr), 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    chk("dwa_ptr2", 32'(demPtr), 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    chk("dwa_ptr3", 32'(demPtr), 32'd15);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    chk("dwa_ptr4", 32'(demPtr), 32'd3);
    chk("dwa_wrap_therm", 32'(thermSel), 32'h18007);

    // Move pointer to 7 (cnt=4), then saturate and full scale
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd256);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd2047);
    chk("ptr_before_sat", 32'(demPtr), 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd1151);
    chk("sat_therm", 32'(thermSel), 32'h1FFFF);
    chk("sat_bin", 32'(binSel), 32'd63);
    chk("sat_red", 32'(redSel), 32'd1);
    chk("sat_flag_hi", 32'(satFlag), 32'd1);
    chk("sat_ptr", 32'(demPtr), 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd450);
    chk("fs_therm", 32'(thermSel), 32'h1FFFF);
    chk("fs_flag_lo", 32'(satFlag), 32'd0);

    // Valid gap after sample 450: outputs hold, pointer frozen
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd999);
    chk("gap_ptr_after450", 32'(demPtr), 32'd14);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd77);
    chk("gap_ptr_frozen", 32'(demPtr), 32'd14);
    chk("gap_out_valid", 32'(outValid), 32'd0);
    chk("gap_bin_hold", 32'(binSel), 32'd2);

    // Power-down during a running stream
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 11'd320);
    chk("pd_therm", 32'(thermSel), 32'h0);
    chk("pd_ptr", 32'(demPtr), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 11'd320);
    chk("pd_discard", 32'(outValid), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 11'd0);
    chk("pd_restart_ptr", 32'(demPtr), 32'd5);

    // dem_ena 1->0 resets pointer to 0
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 11'd320);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
    chk("dem_off_ptr", 32'(demPtr), 32'd0);
    chk("dem_off_therm", 32'(thermSel), 32'h0001F);

    // Randomized stream checked against the model every cycle
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      rd = 11'($urandom_range(1152, 2047));
      else if (r == 1) rd = 11'd1151;
      else if (r == 2) rd = 11'($urandom_range(0, 63));
      else             rd = 11'($urandom_range(0, 1151));
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 49) != 0),
                    ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0), rd);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFails);
    $finish;
  end

endmodule

// File: doc/idac_segment_decoder.md
Name: idac_segment_decoder

Overview:
- Digital front end of the segmented current-steering IDAC.
- Converts a registered 11-bit DAC code into 17 thermometric unit selects, 6 binary selects and 1 redundant LSB select. These selects are retimed by the clock-distribution stage, which drives the switching pairs.
- Applies data-weighted averaging (DWA) rotation across the 17 thermometric units to spread unit-current and timing mismatch.
- Two-stage pipeline, one clock domain.

Parameters:
- N_THERM, 17, number of thermometric unit cells.
- N_BIN, 6, number of binary-weighted bits (bit 0 also drives the redundant cell).
- CODE_W, 11, input code width.
- MAX_CODE, N_THERM*2**N_BIN + 2**N_BIN - 1 (=1151), full-scale code; larger inputs saturate to it.

Ports:
- clkin, input, 1, sampling clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- pdb, input, 1, power-down negate; 0 forces the powered-down state synchronously.
- dem_ena, input, 1, 1 enables DWA rotation; 0 uses a fixed mapping (pointer 0).
- data_valid, input, 1, qualifies data_in.
- data_in, input, CODE_W, unsigned DAC code.
- therm_sel, output, N_THERM, unit select; bit i drives clkout_therm_i / clkoutb_therm_i path.
- bin_sel, output, N_BIN, binary selects.
- bin0_red_sel, output, 1, redundant LSB select.
- out_valid, output, 1, selects updated this cycle.
- sat_flag, output, 1, the sample now on the outputs was saturated.
- dem_ptr, output, 5, current DWA pointer (0..16), for testbus/debug.

Behaviour:
- Reset (rst=1 at an edge): all outputs 0, dem_ptr=0, both pipeline valids 0. rst has priority over pdb.
- pdb=0 at an edge: same effect as reset on the next edge. Data presented while pdb=0 is discarded. Normal operation resumes on the first edge with pdb=1.
- Stage 1, on an edge with data_valid=1:
  - code_s1 = min(data_in, MAX_CODE).
  - sat_s1 = (data_in > MAX_CODE).
  - dem_s1 = dem_ena.
  - v_s1 = 1.
- Stage 1, when data_valid=0: v_s1 = 0, and the code/sat/dem registers hold.
- Stage 2, on an edge with v_s1=1:
  - cnt = code_s1[10:6] (0..17).
  - p = dem_s1 ? dem_ptr : 0.
  - therm_sel[i] = 1 iff ((i - p) mod 17) < cnt.
  - bin_sel = code_s1[5:0].
  - bin0_red_sel = code_s1[0].
  - sat_flag = sat_s1.
  - out_valid = 1.
  - dem_ptr <= dem_s1 ? (p + cnt) mod 17 : 0.
- Stage 2, when v_s1=0: therm_sel, bin_sel, bin0_red_sel, sat_flag and dem_ptr hold (DAC holds its last level); out_valid = 0.
- Latency: data_in at edge N appears on the outputs after edge N+1. Throughput is one sample per clock.
- Boundary: cnt=0 gives therm_sel=0 and the pointer is unchanged.
- Boundary: cnt=17 gives therm_sel all ones and the pointer is unchanged (mod 17).
- Boundary: pointer wrap is modulo 17, never 32; dem_ptr never exceeds 16.
- dem_ena 1->0: the first sample with dem_s1=0 uses p=0 and sets dem_ptr=0. Re-enabling restarts rotation from 0.
- Outputs are registered only; no combinational path from input to output.

Decomposition:
- Package idac_pkg:
  - constants N_THERM, N_BIN, CODE_W, MAX_CODE, PTR_W=5;
  - typedef therm_vec_t (logic [N_THERM-1:0]);
  - typedef bin_vec_t (logic [N_BIN-1:0]).
- Sub-module idac_dwa_rotator:
  - combinational;
  - inputs: cnt, p;
  - outputs: rotated therm vector and next pointer (mod-17 add).
- The top level holds both pipeline stages and the pdb/rst handling.

Test Plan:
- Reset: assert rst 3 cycles with data_valid=1, data_in=500 -> all outputs 0, dem_ptr=0. Release -> first out_valid 2 edges after the first valid sample.
- Fixed mapping: dem_ena=0, data_in=200 -> therm_sel=0x00007, bin_sel=8, bin0_red_sel=0, dem_ptr=0, sat_flag=0.
- DWA sequence: dem_ena=1, four valid samples of data_in=320 (cnt=5) -> dem_ptr 5, 10, 15, 3. Fourth therm_sel=0x18007 (units 15, 16, 0, 1, 2).
- Saturation and full scale:
  - dem_ptr=7, data_in=2047 -> therm_sel=0x1FFFF, bin_sel=63, bin0_red_sel=1, sat_flag=1, dem_ptr stays 7.
  - next data_in=1151 -> same selects, sat_flag=0.
- Valid gap: sample 450, then data_valid=0 for 4 cycles -> outputs hold the 450 mapping, out_valid=0, dem_ptr frozen.
- Power-down mid-stream: pdb=0 for one edge during a running DWA stream -> next edge all selects 0, dem_ptr=0, in-flight sample discarded. pdb=1 -> rotation restarts from pointer 0.
